// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data-memory responder for the CPU M stage. It holds the
//                pipeline with stall_mem for WAIT_CYCLES+1 cycles, then
//                completes the load or store against an internal word RAM.
//                Optional macro DMEM_RESP_ERR_EN adds an err output and
//                rejects misaligned or out-of-range addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        stall_mem,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        busy
`ifdef DMEM_RESP_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int         c_depth = 2 ** ADDR_W;
    localparam logic [3:0] c_wait  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_err_lat;
    logic [31:0]         r_rdata;
    logic                r_rvalid;
    logic                r_err;

    logic                w_req;
    logic                w_accept;
    logic                w_launch;
    logic [ADDR_W-1:0]   w_req_idx;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic                w_cur_write;
    logic                w_req_err;
    logic                w_cur_err;
    logic                w_commit;
    logic [31:0]         w_rd_word;

    assign w_req     = req_read | req_write;
    assign w_req_idx = req_addr[ADDR_W+1:2];
    assign w_accept  = (r_state == S_IDLE) && w_req;

    // The edge that enters DONE is the one that samples the RAM for a load.
    assign w_launch  = (w_accept && (c_wait == 4'd0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With zero wait states the launch edge is also the accept edge, so the
    // live request must steer the read before the latches hold it.
    assign w_rd_idx    = (r_state == S_IDLE) ? w_req_idx : r_idx;
    assign w_cur_write = (r_state == S_IDLE) ? req_write : r_is_write;
    assign w_cur_err   = (r_state == S_IDLE) ? w_req_err : r_err_lat;

`ifdef DMEM_RESP_ERR_EN
    assign w_req_err = (req_addr[1:0] != 2'b00) || (|req_addr[31:ADDR_W+2]);
    assign err       = r_err;
`else
    logic w_unused;
    assign w_req_err = 1'b0;
    assign w_unused  = ^{req_addr[31:ADDR_W+2], req_addr[1:0], r_err};
`endif

    assign w_commit = (r_state == S_DONE) && r_is_write && !r_err_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_err_lat  <= 1'b0;
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;

            if (w_launch) begin
                if (w_cur_err) begin
                    r_err <= 1'b1;
                    if (!w_cur_write) begin
                        r_rdata  <= 32'd0;
                        r_rvalid <= 1'b1;
                    end
                end else if (!w_cur_write) begin
                    r_rdata  <= w_rd_word;
                    r_rvalid <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_write <= req_write;
                        r_idx      <= w_req_idx;
                        r_wdata    <= req_wdata;
                        r_be       <= req_be;
                        r_err_lat  <= w_req_err;
                        r_cnt      <= c_wait;
                        r_state    <= (c_wait == 4'd0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // One byte-wide array per lane keeps byte-enable writes independent.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [c_depth];

        always_ff @(posedge clk) begin
            if (w_commit && r_be[g]) begin
                r_mem[r_idx] <= r_wdata[8*g +: 8];
            end
        end

        assign w_rd_word[8*g +: 8] = r_mem[w_rd_idx];
    end

    // The accept-cycle stall is combinational so the M stage holds at once.
    assign stall_mem = rst_n && (w_accept || (r_state == S_WAIT));
    assign busy      = (r_state != S_IDLE);
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Directed bench for dmem_responder with three configurations
//                (2 wait states, 0 wait states, 16-word RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_read  [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        stall_mem [3];
    logic [31:0] rdata     [3];
    logic        rvalid    [3];
    logic        busy      [3];
`ifdef DMEM_RESP_ERR_EN
    logic        err       [3];
`endif

    int          checks;
    int          failures;
    int          a_n;
    logic        a_rv;
    logic [31:0] a_rd;
    logic        a_bz;
    logic        a_er;
    longint      a_t;
    longint      t_first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read[0]), .req_write(req_write[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .stall_mem(stall_mem[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .busy(busy[0])
`ifdef DMEM_RESP_ERR_EN
        , .err(err[0])
`endif
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read[1]), .req_write(req_write[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .stall_mem(stall_mem[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .busy(busy[1])
`ifdef DMEM_RESP_ERR_EN
        , .err(err[1])
`endif
    );

    dmem_responder #(.ADDR_W(4), .WAIT_CYCLES(2)) u_a4 (
        .clk(clk), .rst_n(rst_n),
        .req_read(req_read[2]), .req_write(req_write[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .stall_mem(stall_mem[2]), .rdata(rdata[2]), .rvalid(rvalid[2]), .busy(busy[2])
`ifdef DMEM_RESP_ERR_EN
        , .err(err[2])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one request, counts stall cycles, and samples the DONE cycle.
    task automatic access(input int d, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        @(negedge clk);
        req_read[d]  = rd;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_be[d]    = be;
        #1;
        a_n = 0;
        while (stall_mem[d] === 1'b1 && a_n < 64) begin
            a_n++;
            @(negedge clk);
            #1;
        end
        a_rv = rvalid[d];
        a_rd = rdata[d];
        a_bz = busy[d];
        a_t  = $time;
`ifdef DMEM_RESP_ERR_EN
        a_er = err[d];
`else
        a_er = 1'b0;
`endif
        req_read[d]  = 1'b0;
        req_write[d] = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        a_er     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_read[i]  = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_be[i]    = 4'd0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stall", stall_mem[0], 0);
        check("rst_rvalid", rvalid[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_rdata", rdata[0], 32'h0);
        rst_n = 1'b1;

        // ---- WAIT_CYCLES=2 ----
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("st_stall_cycles", a_n, 3);
        check("st_busy_done", a_bz, 1);
        check("st_rvalid", a_rv, 0);
        check("st_err", a_er, 0);
        @(negedge clk); #1;
        check("st_busy_after", busy[0], 0);

        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("ld_stall_cycles", a_n, 3);
        check("ld_rvalid", a_rv, 1);
        check("ld_rdata", a_rd, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("ld_rvalid_pulse", rvalid[0], 0);
        check("ld_rdata_held", rdata[0], 32'hDEADBEEF);

        access(0, 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("be_lane0", a_rd, 32'hDEADBEAA);

        access(0, 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        check("be0_stall_cycles", a_n, 3);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("be0_unchanged", a_rd, 32'hDEADBEAA);

        access(0, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
        check("rw_rvalid", a_rv, 0);
        check("rw_rdata_kept", a_rd, 32'hDEADBEAA);
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        check("rw_written", a_rd, 32'h12345678);

`ifdef DMEM_RESP_ERR_EN
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
        check("mis_err", a_er, 1);
        check("mis_rvalid", a_rv, 1);
        check("mis_rdata", a_rd, 32'h0);
`else
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0);
        check("align_rdata", a_rd, 32'hDEADBEAA);
`endif

        // ---- WAIT_CYCLES=0 ----
        access(1, 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF);
        check("w0_st_stall", a_n, 1);
        access(1, 1'b0, 1'b1, 32'h4, 32'h0B0B0B0B, 4'hF);
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        check("w0_ld0_stall", a_n, 1);
        check("w0_ld0_rvalid", a_rv, 1);
        check("w0_ld0_rdata", a_rd, 32'hA0A0A0A0);
        t_first = a_t;
        access(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        check("w0_ld1_rvalid", a_rv, 1);
        check("w0_ld1_rdata", a_rd, 32'h0B0B0B0B);
        check("w0_rvalid_spacing", 32'(a_t - t_first), 32'd20);

        // ---- ADDR_W=4: 0x40 is word 16, one past the 16-word RAM ----
        access(2, 1'b0, 1'b1, 32'h00, 32'h00000077, 4'hF);
        access(2, 1'b0, 1'b1, 32'h40, 32'h00000055, 4'hF);
`ifdef DMEM_RESP_ERR_EN
        check("wrap_st_err", a_er, 1);
        access(2, 1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
        check("wrap_no_write", a_rd, 32'h00000077);
        access(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        check("wrap_ld_err", a_er, 1);
        check("wrap_ld_rvalid", a_rv, 1);
        check("wrap_ld_rdata", a_rd, 32'h0);
`else
        access(2, 1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
        check("wrap_ld0", a_rd, 32'h00000055);
        access(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        check("wrap_ld40", a_rd, 32'h00000055);
`endif

        // ---- reset during WAIT of a store ----
        access(0, 1'b0, 1'b1, 32'h30, 32'h11111111, 4'hF);
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        check("pre_rst_ld", a_rd, 32'h11111111);
        @(negedge clk);
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'h99999999;
        req_be[0]    = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", stall_mem[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_rvalid", rvalid[0], 0);
        check("mid_rst_rdata", rdata[0], 32'h0);
        req_write[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        check("post_rst_rvalid", a_rv, 1);
        check("post_rst_rdata", a_rd, 32'h11111111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
